ahb_master_port: RTL and testbench
==================================

# ahb_master_port

Per-master request front end of the AHB interconnect. Accepts one simple read/write command at a time from a local client and decodes the address into a 4-bit slave select. It drives the arbiter's `hreq`/`sel` pair, waits for `hgrant`, and runs a single AHB NONSEQ transfer (address phase, then data phase). It then returns read data and an error flag to the client. One instance sits upstream of the arbiter for each of masters 1–3.

## Interface
- `ADDR_WIDTH`, 16, client/AHB address width; `[ADDR_WIDTH-1:ADDR_WIDTH-2]` selects the slave.
- `DATA_WIDTH`, 32, data bus width.
- `TIMEOUT`, 255, max wait cycles in REQ or DATA before abort; 8-bit counter.
- `hclk  in  1  clock`; one clock domain.
- `hresetn  in  1  reset`; asynchronous, active-low.
- `cmd_valid  in  1  client command present`
- `cmd_ready  out  1  block can accept a command (high only in IDLE)`
- `cmd_write  in  1  1 = write, 0 = read`
- `cmd_addr  in  ADDR_WIDTH  target address`
- `cmd_wdata  in  DATA_WIDTH  write data`
- `rsp_valid  out  1  one-cycle completion pulse`
- `rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors`
- `rsp_err  out  1  slave error or timeout; valid with rsp_valid`
- `hreq  out  1  bus request to arbiter`
- `sel  out  4  one-hot slave select to arbiter; bits 3:2 = bridge slaves`
- `hgrant  in  1  grant from arbiter`
- `haddr  out  ADDR_WIDTH`, `hwrite  out  1`, `htrans  out  2`, `hwdata  out  DATA_WIDTH`: AHB master outputs.
- `hrdata  in  DATA_WIDTH`, `hready_out  in  1`, `hresp  in  1`: from the selected slave.

## Operation
- States: IDLE, REQ, ADDR, DATA, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid`, the block latches write, addr and wdata, then goes to REQ. `sel` is registered from the decode: top address bits 00→0001, 01→0010, 10→0100, 11→1000.
- REQ: `hreq`=1 and `sel` held. When `hgrant`=1 the block goes to ADDR. The timeout counter runs.
- ADDR (exactly 1 cycle): `haddr`=latched addr, `hwrite`=latched write, `htrans`=2'b10 (NONSEQ). Then the block goes to DATA.
- DATA: `htrans`=2'b00 and `hwdata`=latched wdata (0 for reads). The block waits for `hready_out`=1.
  - On `hready_out`=1 with `hresp`=0: capture `hrdata` (reads only), set err=0, go to RESP.
  - On `hready_out`=1 with `hresp`=1: set err=1, force rdata to 0, go to RESP.
- RESP (1 cycle): `rsp_valid`=1 and `hreq`=0. `sel` is cleared to 0000. Then the block goes to IDLE.
- `hreq` and `sel` stay stable from REQ through DATA. The arbiter therefore never sees a select change mid-grant.
- Timeout: the counter clears on entry to REQ and on entry to DATA and increments every cycle in those states. At count == TIMEOUT the block goes to RESP with err=1 and rdata=0. In REQ, the block ignores an `hgrant` that arrives in the expiry cycle.
- `hgrant` is ignored outside REQ; deassertion during ADDR/DATA has no effect.
- `cmd_valid` is ignored outside IDLE, and there is no queueing.

## Timing
- Reset values: state IDLE, `hreq` 0, `sel` 0000, `htrans` 00, `haddr`/`hwdata` 0, `hwrite` 0, `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0, counter 0. `cmd_ready` is combinational from state, so it reads 1 in IDLE.
- Accept at edge N: `hreq`/`sel` are visible after N+1.
- Minimum latency from accept to `rsp_valid` is 4 cycles, given `hgrant` at the first REQ cycle and zero-wait `hready_out`.
- `hreq` is low in RESP. The arbiter returns to IDLE on completion and samples `hreq`=0, so it does not re-grant a stale request.
- Back-to-back commands: the next accept can occur at the earliest 1 cycle after RESP.
- All outputs are registered except `cmd_ready`.
- Reset asserted mid-transfer aborts immediately to reset values. No `rsp_valid` is emitted for the aborted command.

## Structure
- Package `ahb_master_pkg`: state encoding, HTRANS_IDLE/HTRANS_NONSEQ constants, and SEL codes (SEL_S0..SEL_B1).
- Sub-module `ahb_addr_decode`: combinational address-bits → one-hot `sel`. It is shared with the interconnect's slave-side mux.
- The FSM, timeout counter and output registers live in `ahb_master_port`.

## Test plan
- Write, addr 0x1234, wdata 0xDEADBEEF; `hgrant` the cycle after `hreq`; zero-wait slave. Expect: `sel`=0001, one NONSEQ with `hwrite`=1, `hwdata`=0xDEADBEEF, and `rsp_valid` 4 cycles after accept with err=0.
- Read, addr 0x8010; `hgrant` after 3 cycles; `hready_out` low 2 cycles; `hrdata`=0xA5A5A5A5. Expect: `sel`=0100, `rsp_rdata`=0xA5A5A5A5, err=0, and `hreq` low in RESP.
- Read with `hready_out`=1 and `hresp`=1 in DATA. Expect: `rsp_err`=1 and `rsp_rdata`=0.
- `hgrant` never asserted, TIMEOUT=255. Expect: `rsp_valid` with err=1 exactly 256 cycles after entering REQ, and no NONSEQ issued.
- Assert `hresetn` low during DATA. Expect: all outputs at reset values immediately, no `rsp_valid`, and a new command accepted normally after release.
- Back-to-back commands to addrs 0x4000 then 0xC000. Expect: `sel` 0010, then 0000 for one cycle in RESP, then 1000 after the next accept.

Source files
------------

// File: rtl/ahb_master_pkg.sv
// Shared types and constants for the per-master AHB request front end.
// Holds the FSM state encoding, HTRANS codes and the one-hot slave select codes.
package ahb_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_ADDR = 3'd2,
      ST_DATA = 3'd3,
      ST_RESP = 3'd4
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [3:0] SEL_NONE = 4'b0000;
   localparam logic [3:0] SEL_S0   = 4'b0001;
   localparam logic [3:0] SEL_S1   = 4'b0010;
   localparam logic [3:0] SEL_B0   = 4'b0100;
   localparam logic [3:0] SEL_B1   = 4'b1000;

   localparam int TIMER_WIDTH = 8;

endpackage

// File: rtl/ahb_addr_decode.sv
// Top-two-address-bits to one-hot slave select; also used by the slave-side mux.
module ahb_addr_decode
   import ahb_master_pkg::*;
(
   input  logic [1:0] slave_bits,
   output logic [3:0] sel
);

   // one-hot select lookup
   always_comb begin
      sel = SEL_NONE;
      case (slave_bits)
         2'b00:   sel = SEL_S0;
         2'b01:   sel = SEL_S1;
         2'b10:   sel = SEL_B0;
         2'b11:   sel = SEL_B1;
         default: sel = SEL_NONE;
      endcase
   end

endmodule

// File: rtl/ahb_master_port.sv
// Per-master AHB front end: one client command becomes arbiter request, grant wait,
// a single NONSEQ transfer and a one-cycle response pulse, with a bounded wait timer.
module ahb_master_port
   import ahb_master_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  hclk,
   input  logic                  hresetn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  hreq,
   output logic [3:0]            sel,
   input  logic                  hgrant,
   output logic [ADDR_WIDTH-1:0] haddr,
   output logic                  hwrite,
   output logic [1:0]            htrans,
   output logic [DATA_WIDTH-1:0] hwdata,
   input  logic [DATA_WIDTH-1:0] hrdata,
   input  logic                  hready_out,
   input  logic                  hresp
);

   localparam logic [TIMER_WIDTH-1:0] TIMEOUT_C = TIMER_WIDTH'(TIMEOUT);

   state_t                  state_r, state_nx_s;
   logic                    write_r, write_nx_s;
   logic [ADDR_WIDTH-1:0]   addr_r, addr_nx_s;
   logic [DATA_WIDTH-1:0]   wdata_r, wdata_nx_s;
   logic [TIMER_WIDTH-1:0]  cnt_r, cnt_nx_s;
   logic                    hreq_r, hreq_nx_s;
   logic [3:0]              sel_r, sel_nx_s;
   logic [1:0]              htrans_r, htrans_nx_s;
   logic [ADDR_WIDTH-1:0]   haddr_r, haddr_nx_s;
   logic                    hwrite_r, hwrite_nx_s;
   logic [DATA_WIDTH-1:0]   hwdata_r, hwdata_nx_s;
   logic                    rsp_valid_r, rsp_valid_nx_s;
   logic [DATA_WIDTH-1:0]   rsp_rdata_r, rsp_rdata_nx_s;
   logic                    rsp_err_r, rsp_err_nx_s;
   logic [3:0]              dec_sel_s;
   logic                    accept_s;
   logic                    timeout_s;
   logic                    data_ok_s;

   ahb_addr_decode u_decode (
      .slave_bits (cmd_addr[ADDR_WIDTH-1 -: 2]),
      .sel        (dec_sel_s)
   );

   assign accept_s  = (state_r == ST_IDLE) && cmd_valid;
   assign timeout_s = (cnt_r == TIMEOUT_C);
   // expiry wins over a late grant or a late hready_out
   assign data_ok_s = (state_r == ST_DATA) && !timeout_s && hready_out && !hresp;
   assign cmd_ready = (state_r == ST_IDLE);

   // state register
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // next-state decode
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) state_nx_s = ST_REQ;
            else           state_nx_s = ST_IDLE;
         end
         ST_REQ: begin
            if (timeout_s)   state_nx_s = ST_RESP;
            else if (hgrant) state_nx_s = ST_ADDR;
            else             state_nx_s = ST_REQ;
         end
         ST_ADDR: state_nx_s = ST_DATA;
         ST_DATA: begin
            if (timeout_s || hready_out) state_nx_s = ST_RESP;
            else                         state_nx_s = ST_DATA;
         end
         ST_RESP: state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // next values of the latched command, timer and registered outputs
   always_comb begin
      write_nx_s = write_r;
      addr_nx_s  = addr_r;
      wdata_nx_s = wdata_r;
      sel_nx_s   = sel_r;
      cnt_nx_s   = {TIMER_WIDTH{1'b0}};
      if (accept_s) begin
         write_nx_s = cmd_write;
         addr_nx_s  = cmd_addr;
         wdata_nx_s = cmd_wdata;
         sel_nx_s   = dec_sel_s;
      end else if (state_nx_s == ST_RESP) begin
         sel_nx_s   = SEL_NONE;
      end else begin
         sel_nx_s   = sel_r;
      end
      if (state_nx_s != state_r) begin
         cnt_nx_s = {TIMER_WIDTH{1'b0}};
      end else if ((state_r == ST_REQ) || (state_r == ST_DATA)) begin
         cnt_nx_s = cnt_r + {{(TIMER_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         cnt_nx_s = {TIMER_WIDTH{1'b0}};
      end
      hreq_nx_s      = (state_nx_s == ST_REQ) || (state_nx_s == ST_ADDR) || (state_nx_s == ST_DATA);
      htrans_nx_s    = (state_nx_s == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
      haddr_nx_s     = (state_nx_s == ST_ADDR) ? addr_r : {ADDR_WIDTH{1'b0}};
      hwrite_nx_s    = (state_nx_s == ST_ADDR) ? write_r : 1'b0;
      hwdata_nx_s    = ((state_nx_s == ST_DATA) && write_r) ? wdata_r : {DATA_WIDTH{1'b0}};
      rsp_valid_nx_s = (state_nx_s == ST_RESP);
      rsp_err_nx_s   = (state_nx_s == ST_RESP) && !data_ok_s;
      rsp_rdata_nx_s = ((state_nx_s == ST_RESP) && data_ok_s && !write_r) ? hrdata
                                                                          : {DATA_WIDTH{1'b0}};
   end

   // command latch, timer and output registers
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         write_r     <= 1'b0;
         addr_r      <= {ADDR_WIDTH{1'b0}};
         wdata_r     <= {DATA_WIDTH{1'b0}};
         cnt_r       <= {TIMER_WIDTH{1'b0}};
         hreq_r      <= 1'b0;
         sel_r       <= SEL_NONE;
         htrans_r    <= HTRANS_IDLE;
         haddr_r     <= {ADDR_WIDTH{1'b0}};
         hwrite_r    <= 1'b0;
         hwdata_r    <= {DATA_WIDTH{1'b0}};
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= {DATA_WIDTH{1'b0}};
         rsp_err_r   <= 1'b0;
      end else begin
         write_r     <= write_nx_s;
         addr_r      <= addr_nx_s;
         wdata_r     <= wdata_nx_s;
         cnt_r       <= cnt_nx_s;
         hreq_r      <= hreq_nx_s;
         sel_r       <= sel_nx_s;
         htrans_r    <= htrans_nx_s;
         haddr_r     <= haddr_nx_s;
         hwrite_r    <= hwrite_nx_s;
         hwdata_r    <= hwdata_nx_s;
         rsp_valid_r <= rsp_valid_nx_s;
         rsp_rdata_r <= rsp_rdata_nx_s;
         rsp_err_r   <= rsp_err_nx_s;
      end
   end

   assign hreq      = hreq_r;
   assign sel       = sel_r;
   assign htrans    = htrans_r;
   assign haddr     = haddr_r;
   assign hwrite    = hwrite_r;
   assign hwdata    = hwdata_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_ahb_master_port.sv
// Directed bench for ahb_master_port: expected responses are queued at command issue
// and checked by a monitor when rsp_valid appears; bus-side behaviour is checked inline.
module tb_ahb_master_port;

   logic        hclk;
   logic        hresetn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [15:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        hreq;
   logic [3:0]  sel;
   logic        hgrant;
   logic [15:0] haddr;
   logic        hwrite;
   logic [1:0]  htrans;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready_out;
   logic        hresp;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   nonseq_cnt = 0;

   ahb_master_port dut (
      .hclk       (hclk),
      .hresetn    (hresetn),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_write  (cmd_write),
      .cmd_addr   (cmd_addr),
      .cmd_wdata  (cmd_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .hreq       (hreq),
      .sel        (sel),
      .hgrant     (hgrant),
      .haddr      (haddr),
      .hwrite     (hwrite),
      .htrans     (htrans),
      .hwdata     (hwdata),
      .hrdata     (hrdata),
      .hready_out (hready_out),
      .hresp      (hresp)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   // present one command for one cycle; optionally queue its expected response
   task automatic send(input logic w, input logic [15:0] a, input logic [31:0] d,
                       input logic push, input logic [31:0] exp_rdata, input logic exp_err);
      exp_t e;
      chk("cmd_ready_before_accept", {63'd0, cmd_ready}, 64'd1);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      if (push) begin
         e.rdata = exp_rdata;
         e.err   = exp_err;
         sb.push_back(e);
      end
      tick();
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 16'h0000;
      cmd_wdata = 32'h0;
   endtask

   // response monitor and NONSEQ counter
   always @(negedge hclk) begin
      if (htrans === 2'b10) nonseq_cnt++;
      if (rsp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
            chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
         end
      end
   end

   initial begin
      int n;
      int base;
      hresetn    = 1'b0;
      cmd_valid  = 1'b0;
      cmd_write  = 1'b0;
      cmd_addr   = 16'h0000;
      cmd_wdata  = 32'h0;
      hgrant     = 1'b0;
      hrdata     = 32'h0;
      hready_out = 1'b1;
      hresp      = 1'b0;
      #12;
      chk("reset_ctrl", {56'd0, hreq, sel, htrans, rsp_valid}, 64'd0);
      chk("reset_data", {16'd0, haddr, hwdata} | {32'd0, rsp_rdata} | {63'd0, hwrite | rsp_err}, 64'd0);
      chk("reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      tick();
      hresetn = 1'b1;
      tick();

      // zero-wait write, grant in first REQ cycle
      hgrant = 1'b1;
      send(1'b1, 16'h1234, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
      chk("w_req_hreq", {63'd0, hreq}, 64'd1);
      chk("w_req_sel", {60'd0, sel}, 64'h1);
      chk("w_req_rsp", {63'd0, rsp_valid}, 64'd0);
      tick();
      hgrant = 1'b0;
      chk("w_addr_phase", {44'd0, htrans, hwrite, haddr}, {44'd0, 2'b10, 1'b1, 16'h1234});
      tick();
      chk("w_data_htrans", {62'd0, htrans}, 64'd0);
      chk("w_data_hwdata", {32'd0, hwdata}, 64'hDEADBEEF);
      chk("w_data_sel_hreq", {59'd0, hreq, sel}, {59'd0, 1'b1, 4'b0001});
      tick();
      chk("w_rsp_at_lat4", {63'd0, rsp_valid}, 64'd1);
      chk("w_rsp_hreq_sel", {59'd0, hreq, sel}, 64'd0);
      tick();
      chk("w_idle_ready", {62'd0, cmd_ready, rsp_valid}, 64'b10);

      // read: grant on third REQ cycle, two wait states
      hready_out = 1'b0;
      send(1'b0, 16'h8010, 32'h0, 1'b1, 32'hA5A5A5A5, 1'b0);
      chk("r_req_sel", {60'd0, sel}, 64'h4);
      tick();
      tick();
      chk("r_still_req", {62'd0, hreq, htrans[1]}, 64'b10);
      hgrant = 1'b1;
      tick();
      hgrant = 1'b0;
      chk("r_addr_phase", {44'd0, htrans, hwrite, haddr}, {44'd0, 2'b10, 1'b0, 16'h8010});
      tick();
      chk("r_data_hwdata", {32'd0, hwdata}, 64'd0);
      tick();
      tick();
      chk("r_wait_hold", {58'd0, rsp_valid, hreq, sel}, {58'd0, 1'b0, 1'b1, 4'b0100});
      hready_out = 1'b1;
      hrdata     = 32'hA5A5A5A5;
      tick();
      chk("r_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("r_rsp_hreq_low", {63'd0, hreq}, 64'd0);
      tick();

      // slave error response forces rdata to zero
      hgrant = 1'b1;
      hresp  = 1'b1;
      hrdata = 32'hFFFFFFFF;
      send(1'b0, 16'h4004, 32'h0, 1'b1, 32'h0, 1'b1);
      chk("e_req_sel", {60'd0, sel}, 64'h2);
      tick();
      tick();
      tick();
      chk("e_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      hresp  = 1'b0;
      hgrant = 1'b0;
      tick();

      // no grant: timeout after 256 REQ cycles; a grant in the expiry cycle is ignored
      base = nonseq_cnt;
      send(1'b0, 16'h0100, 32'h0, 1'b1, 32'h0, 1'b1);
      n = 0;
      while (hreq === 1'b1 && rsp_valid !== 1'b1 && n < 400) begin
         n++;
         hgrant = (n == 256);
         tick();
      end
      hgrant = 1'b0;
      chk("t_req_cycles", n, 64'd256);
      chk("t_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      tick();
      tick();
      chk("t_no_nonseq", nonseq_cnt - base, 64'd0);

      // reset during DATA aborts with no response
      hgrant     = 1'b1;
      hready_out = 1'b0;
      send(1'b1, 16'h1ABC, 32'h12345678, 1'b0, 32'h0, 1'b0);
      tick();
      tick();
      chk("a_in_data", {32'd0, hwdata}, 64'h12345678);
      hresetn = 1'b0;
      #1;
      chk("a_reset_ctrl", {56'd0, hreq, sel, htrans, rsp_valid}, 64'd0);
      chk("a_reset_data", {16'd0, haddr, hwdata} | {32'd0, rsp_rdata} | {63'd0, hwrite | rsp_err}, 64'd0);
      chk("a_reset_ready", {63'd0, cmd_ready}, 64'd1);
      tick();
      tick();
      hresetn    = 1'b1;
      hready_out = 1'b1;
      tick();
      send(1'b0, 16'hC008, 32'h0, 1'b1, 32'h0BADF00D, 1'b0);
      chk("a_new_sel", {60'd0, sel}, 64'h8);
      tick();
      tick();
      hrdata = 32'h0BADF00D;
      tick();
      chk("a_new_rsp", {63'd0, rsp_valid}, 64'd1);
      tick();

      // back-to-back commands
      send(1'b1, 16'h4000, 32'h00000011, 1'b1, 32'h0, 1'b0);
      chk("b_first_sel", {60'd0, sel}, 64'h2);
      tick();
      tick();
      tick();
      chk("b_rsp_sel_clear", {59'd0, rsp_valid, sel}, {59'd0, 1'b1, 4'b0000});
      tick();
      hrdata = 32'h00000077;
      send(1'b0, 16'hC000, 32'h0, 1'b1, 32'h00000077, 1'b0);
      chk("b_second_sel", {59'd0, hreq, sel}, {59'd0, 1'b1, 4'b1000});
      tick();
      tick();
      tick();
      chk("b_second_rsp", {63'd0, rsp_valid}, 64'd1);
      tick();
      hgrant = 1'b0;
      tick();

      chk("sb_drained", sb.size(), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
